// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier: one partial product per clock, signed or unsigned per transaction.
// Optional macro MULT_EARLY_TERM_EN: leave CALC as soon as no multiplier bits remain.
module multiplier_seq #(
    parameter int SIZE = 8,
    localparam int CNT_W = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   op_a,
    input  logic [SIZE-1:0]   op_b,
    input  logic              is_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] result,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2*SIZE-1:0]   sh_a_q, sh_a_d;
    logic [SIZE-1:0]     sh_b_q, sh_b_d;
    logic [2*SIZE-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [2*SIZE-1:0]   result_q, result_d;

    logic [SIZE-1:0]     a_mag, b_mag;
    logic [2*SIZE-1:0]   acc_sum;
    logic [SIZE-1:0]     sh_b_shift;
    logic [CNT_W-1:0]    cnt_inc;
    logic                calc_last;

    // Magnitudes; the most negative value maps to 2^(SIZE-1), which still fits unsigned.
    assign a_mag      = (is_signed && op_a[SIZE-1]) ? -op_a : op_a;
    assign b_mag      = (is_signed && op_b[SIZE-1]) ? -op_b : op_b;
    assign acc_sum    = sh_b_q[0] ? (acc_q + sh_a_q) : acc_q;
    assign sh_b_shift = sh_b_q >> 1;
    assign cnt_inc    = cnt_q + CNT_W'(1);

`ifdef MULT_EARLY_TERM_EN
    assign calc_last = (cnt_inc == CNT_W'(SIZE)) || (sh_b_shift == '0);
`else
    assign calc_last = (cnt_inc == CNT_W'(SIZE));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (calc_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_a_d = {{SIZE{1'b0}}, a_mag};
                    sh_b_d = b_mag;
                    acc_d  = '0;
                    cnt_d  = '0;
                    // A zero operand never yields a negative product.
                    neg_d  = is_signed & (op_a[SIZE-1] ^ op_b[SIZE-1]) & (|op_a) & (|op_b);
                end
            end
            CALC: begin
                acc_d  = acc_sum;
                sh_a_d = sh_a_q << 1;
                sh_b_d = sh_b_shift;
                cnt_d  = cnt_inc;
                if (calc_last) begin
                    result_d = neg_q ? -acc_sum : acc_sum;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = result_q;
    end

endmodule
